debug_brkpt: RTL

DEBUG_BRKPT -- requirements
Module: debug_brkpt

---
 rtl/debug_brkpt.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/debug_brkpt.sv
// rtl/debug_brkpt.sv - PC breakpoint, pass counter and run watchdog for the CPU debug port
//
// Ports:
//   clk, rst            system clock, asynchronous active-high reset
//   clken               CPU clock enable; qualifies loadIR/loadVMA
//   loadIR, loadVMA     microcode strobes (IR load samples the PC)
//   debugDATA[0:35]     ALU register readback, PC in [36-PCW:35]
//   debugADDR[0:3]      ALU register select, fixed to the PC register
//   cpuRUN, cpuHALT     CPU run / halt status
//   regWR, regADDR,     host register port: 0 BRKCTL, 1 PASSCNT,
//   regDATI, regDATO      2 WDLIM, 3 STATUS (write-1-to-clear flags)
//   brkHALT             halt request to the CPU
//   brkIRQ              registered hit|stuck interrupt to the host
module debug_brkpt #(
  parameter int WDW = 24,
  parameter int PCW = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clken,
  input  logic        loadIR,
  input  logic        loadVMA,
  input  logic [0:35] debugDATA,
  output logic [0:3]  debugADDR,
  input  logic        cpuRUN,
  input  logic        cpuHALT,
  input  logic        regWR,
  input  logic [0:1]  regADDR,
  input  logic [0:35] regDATI,
  output logic [0:35] regDATO,
  output logic        brkHALT,
  output logic        brkIRQ
);

  typedef enum logic [1:0] {IDLE, ARMED, HALTREQ, HALTED} state_t;

  state_t           state, state_n;
  logic             brk_en, brk_wden;
  logic [PCW-1:0]   brk_pc;
  logic [15:0]      passcnt;
  logic [WDW-1:0]   wdlim;
  logic [WDW-1:0]   wd_cnt, wd_nxt;
  logic             hit, stuck;
  logic [PCW-1:0]   pc_sample;

  // Only part of the host data word and the readback word carry fields.
  logic             unused_bits;
  assign unused_bits = ^{debugDATA, regDATI};

  assign debugADDR = 4'b0001;

  logic           wr_ctl, wr_pass, wr_wdl, wr_sts;
  logic           dis_wr, en_wr;
  logic           ir_ld, pc_match, match_ev, hit_evt, dec_evt;
  logic           stuck_evt, wd_halt;
  logic [PCW-1:0] pc_in;

  assign wr_ctl  = regWR & (regADDR == 2'd0);
  assign wr_pass = regWR & (regADDR == 2'd1);
  assign wr_wdl  = regWR & (regADDR == 2'd2);
  assign wr_sts  = regWR & (regADDR == 2'd3);
  assign dis_wr  = wr_ctl & ~regDATI[0];
  assign en_wr   = wr_ctl &  regDATI[0];

  assign pc_in    = debugDATA[36-PCW:35];
  assign ir_ld    = clken & loadIR;
  assign pc_match = ir_ld & (pc_in == brk_pc);
  // A disable written in the same cycle as a match takes precedence.
  assign match_ev = (state == ARMED) & pc_match & ~dis_wr;
  assign hit_evt  = match_ev & (passcnt == 16'd0);
  assign dec_evt  = match_ev & (passcnt != 16'd0);

  // Watchdog: the >= branch saturates and also pulls the count down if the
  // host lowers the limit below it; a zero limit pins the count at zero.
  always_comb begin
    wd_nxt = wd_cnt;
    if (clken & (loadIR | loadVMA))
      wd_nxt = '0;
    else if (wd_cnt >= wdlim)
      wd_nxt = wdlim;
    else if (clken & cpuRUN)
      wd_nxt = wd_cnt + WDW'(1);
  end

  // Edge event so a host-cleared stuck flag stays clear while saturated.
  assign stuck_evt = (wdlim != '0) & (wd_cnt != wdlim) & (wd_nxt == wdlim);
  assign wd_halt   = brk_wden & (stuck | stuck_evt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      brk_en    <= 1'b0;
      brk_wden  <= 1'b0;
      brk_pc    <= '0;
      passcnt   <= '0;
      wdlim     <= '0;
      wd_cnt    <= '0;
      hit       <= 1'b0;
      stuck     <= 1'b0;
      pc_sample <= '0;
      brkIRQ    <= 1'b0;
    end else begin
      state  <= state_n;
      wd_cnt <= wd_nxt;
      brkIRQ <= hit | stuck;
      if (wr_ctl) begin
        brk_en   <= regDATI[0];
        brk_wden <= regDATI[1];
        brk_pc   <= regDATI[36-PCW:35];
      end
      if (wr_pass)
        passcnt <= regDATI[20:35];
      else if (dec_evt)
        passcnt <= passcnt - 16'd1;
      if (wr_wdl)
        wdlim <= regDATI[36-WDW:35];
      if (ir_ld)
        pc_sample <= pc_in;
      // Set events beat a simultaneous host clear.
      if (hit_evt)
        hit <= 1'b1;
      else if (wr_sts & regDATI[0])
        hit <= 1'b0;
      if (stuck_evt)
        stuck <= 1'b1;
      else if (wr_sts & regDATI[1])
        stuck <= 1'b0;
    end
  end

  // brkHALT decodes the state directly so reset drops it without a clock.
  always_comb begin
    state_n = state;
    brkHALT = 1'b0;
    case (state)
      IDLE: begin
        if (wd_halt)
          state_n = HALTREQ;
        else if (en_wr)
          state_n = ARMED;
      end
      ARMED: begin
        if (dis_wr)
          state_n = IDLE;
        else if (hit_evt | wd_halt)
          state_n = HALTREQ;
      end
      HALTREQ: begin
        brkHALT = 1'b1;
        if (dis_wr)
          state_n = IDLE;
        else if (cpuHALT)
          state_n = HALTED;
      end
      HALTED: begin
        if (wr_sts & regDATI[0])
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    regDATO = '0;
    case (regADDR)
      2'd0: begin
        regDATO[0]           = brk_en;
        regDATO[1]           = brk_wden;
        regDATO[36-PCW:35]   = brk_pc;
      end
      2'd1: regDATO[20:35]         = passcnt;
      2'd2: regDATO[36-WDW:35]     = wdlim;
      default: begin
        regDATO[0]           = hit;
        regDATO[1]           = stuck;
        regDATO[36-PCW:35]   = pc_sample;
      end
    endcase
  end

endmodule
